exp_pwl_pipe: RTL
=================

// Module: exp_pwl_pipe
// PURPOSE
//  Pipelined, parametrised piecewise-linear exp(x) approximator for the QFT fixed-point datapath.
//  Evaluates y = ((x*slope[k]) >>> FRAC_WIDTH) + icpt[k] and saturates to the output width.
//  k is selected from NUM_SEG uniform segments. The coefficient table is run-time writable.
//  Valid/ready streaming on input and output; full throughput of one sample per cycle.
// PARAMETERS
//  TOTAL_WIDTH  8    signed data width of x and y
//  FRAC_WIDTH   4    fractional bits; product is shifted right arithmetically by this amount
//  COEF_WIDTH   32   signed width of the slope and intercept table entries
//  NUM_SEG      16   number of segments (>=2); address width SEG_AW = $clog2(NUM_SEG)
//  BP_MIN       -80  lower edge of segment 0
//  BP_STEP      10   segment width, in x LSBs (>0)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              input sample valid
//  in_ready   out  1              block can accept a sample
//  in_x       in   TOTAL_WIDTH    signed input x
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts the result
//  out_y      out  TOTAL_WIDTH    signed saturated exp approximation
//  out_sat    out  1              1 = out_y was clamped
//  cfg_we     in   1              coefficient table write strobe
//  cfg_addr   in   SEG_AW         segment index to write; ignored when >= NUM_SEG
//  cfg_slope  in   COEF_WIDTH     new slope value
//  cfg_icpt   in   COEF_WIDTH     new intercept value
// BEHAVIOUR
//  Reset:
//   - out_valid=0, out_y=0, out_sat=0; all stage valids cleared; in_ready=1 once rst deasserts.
//   - Table entries 0..15 reset to slope {0,0,1,1,2,3,6,12,22,42,78,145,271,506,945,1766}
//     and icpt {1,1,2,4,6,9,13,16,16,4,-41,-167,-482,-1217,-2864,-6454}.
//   - Entries >= 16 reset to 0.
//   - Reset mid-operation discards every in-flight sample and restores the table.
//  Segment select: k = smallest i with x < BP_MIN+(i+1)*BP_STEP, for i in 0..NUM_SEG-2; else NUM_SEG-1.
//   - x below BP_MIN therefore uses segment 0.
//   - Compare in at least TOTAL_WIDTH+1 signed bits so breakpoints never wrap.
//  Pipeline, 3 register stages; latency is 3 cycles from in_valid&&in_ready to out_valid:
//   - S1: select k; register x, slope[k], icpt[k].
//   - S2: register full product x*slope, TOTAL_WIDTH+COEF_WIDTH bits, signed.
//   - S3: r = (prod >>> FRAC_WIDTH) + icpt, at least COEF_WIDTH+1 bits.
//     out_y = r > 2^(W-1)-1 ? max : r < -2^(W-1) ? min : r[W-1:0]; out_sat set when clamped.
//   - The shift is floor rounding, not round-to-nearest.
//  Handshake:
//   - A stage loads when it is empty or its contents advance in the same cycle.
//   - in_ready = !S1.valid || S1 advances. out_valid holds with out_y/out_sat stable until out_ready.
//   - With out_ready=0 the pipeline fills to 3 samples, then in_ready=0. No loss, no duplication, order kept.
//  Table writes:
//   - A write takes effect at the clock edge where cfg_we=1.
//   - A sample accepted in the same cycle reads the OLD entry; the next cycle's sample sees the new one.
//   - Samples already past S1 keep their captured coefficients.
//   - Writes are independent of the handshake and never stall.
// TESTING
//  1 Reset, then x=0 -> out_y=16 (seg 8), out_sat=0, out_valid exactly 3 cycles after accept.
//  2 Back-to-back x=5,-15,-128 -> y=22, 7 (floor -5.625 -> -6, +13), 1; one result per cycle.
//  3 x=127 -> raw 7563 -> out_y=127, out_sat=1. Force large negative via cfg (seg 0 icpt=-500) with x=-128 -> out_y=-128, out_sat=1.
//  4 cfg_we seg 8 slope=16 icpt=0 in the same cycle as accepting x=5 -> 22; next x=5 -> 5.
//  5 Stream 10 samples with out_ready low for 5 cycles mid-stream -> in_ready drops after 3 held; all 10 out, in order.
//  6 Assert rst with 2 samples in flight plus a modified table -> out_valid=0 immediately, no stale output, x=0 -> 16.

Source files
------------

// File: rtl/exp_pwl_pipe.sv
// exp_pwl_pipe
// Piecewise-linear exp(x) approximator, three register stages, one sample per
// clock. Each segment k has its own slope/intercept entry in a writable table:
//     y = sat( ((x * slope[k]) >>> FRAC_WIDTH) + icpt[k] )
// The segment is chosen from NUM_SEG uniform breakpoints starting at BP_MIN.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake, in_x is the signed sample
//   out_valid/out_ready  output handshake, out_y is the saturated result,
//                        out_sat flags a clamped result
//   cfg_we/cfg_addr      coefficient write strobe and segment index
//   cfg_slope/cfg_icpt   new coefficient pair for segment cfg_addr
module exp_pwl_pipe #(
    parameter int TOTAL_WIDTH = 8,
    parameter int FRAC_WIDTH  = 4,
    parameter int COEF_WIDTH  = 32,
    parameter int NUM_SEG     = 16,
    parameter int BP_MIN      = -80,
    parameter int BP_STEP     = 10,
    localparam int SEG_AW     = $clog2(NUM_SEG)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [TOTAL_WIDTH-1:0] in_x,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [TOTAL_WIDTH-1:0] out_y,
    output logic                          out_sat,
    input  logic                          cfg_we,
    input  logic [SEG_AW-1:0]             cfg_addr,
    input  logic signed [COEF_WIDTH-1:0]  cfg_slope,
    input  logic signed [COEF_WIDTH-1:0]  cfg_icpt
);

    localparam int PROD_W = TOTAL_WIDTH + COEF_WIDTH;
    // One guard bit above the product so the intercept add cannot overflow.
    localparam int R_W    = PROD_W + 1;

    localparam logic signed [R_W-1:0] Y_MAX_R = R_W'((2 ** (TOTAL_WIDTH - 1)) - 1);
    localparam logic signed [R_W-1:0] Y_MIN_R = R_W'(-(2 ** (TOTAL_WIDTH - 1)));
    localparam logic signed [TOTAL_WIDTH-1:0] Y_MAX = {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
    localparam logic signed [TOTAL_WIDTH-1:0] Y_MIN = {1'b1, {(TOTAL_WIDTH-1){1'b0}}};

    function automatic logic signed [COEF_WIDTH-1:0] slope_rst(input int i);
        int v;
        v = 0;
        case (i)
            2, 3:    v = 1;
            4:       v = 2;
            5:       v = 3;
            6:       v = 6;
            7:       v = 12;
            8:       v = 22;
            9:       v = 42;
            10:      v = 78;
            11:      v = 145;
            12:      v = 271;
            13:      v = 506;
            14:      v = 945;
            15:      v = 1766;
            default: v = 0;
        endcase
        return COEF_WIDTH'(v);
    endfunction

    function automatic logic signed [COEF_WIDTH-1:0] icpt_rst(input int i);
        int v;
        v = 0;
        case (i)
            0, 1:    v = 1;
            2:       v = 2;
            3:       v = 4;
            4:       v = 6;
            5:       v = 9;
            6:       v = 13;
            7, 8:    v = 16;
            9:       v = 4;
            10:      v = -41;
            11:      v = -167;
            12:      v = -482;
            13:      v = -1217;
            14:      v = -2864;
            15:      v = -6454;
            default: v = 0;
        endcase
        return COEF_WIDTH'(v);
    endfunction

    logic signed [COEF_WIDTH-1:0] tbl_slope [NUM_SEG];
    logic signed [COEF_WIDTH-1:0] tbl_icpt  [NUM_SEG];

    // Stage registers
    logic                          v1, v2;
    logic signed [TOTAL_WIDTH-1:0] x1;
    logic signed [COEF_WIDTH-1:0]  slope1, icpt1, icpt2;
    logic signed [PROD_W-1:0]      prod2;

    logic              load1, load2, load3;
    logic [SEG_AW-1:0] k_sel;
    int                xi;

    logic signed [PROD_W-1:0]      prod_sh;
    logic signed [R_W-1:0]         r_sum;
    logic signed [TOTAL_WIDTH-1:0] y_n;
    logic                          sat_n;

    // A stage takes new data when empty or when its current contents move on.
    assign load3    = !out_valid || out_ready;
    assign load2    = !v2 || load3;
    assign load1    = !v1 || load2;
    assign in_ready = load1;

    // Breakpoints are compared as 32-bit integers so they never wrap at x's width.
    always_comb begin
        xi    = int'(in_x);
        k_sel = SEG_AW'(NUM_SEG - 1);
        for (int i = NUM_SEG - 2; i >= 0; i--) begin
            if (xi < BP_MIN + (i + 1) * BP_STEP) begin
                k_sel = SEG_AW'(i);
            end
        end
    end

    // Floor shift of the product, then intercept add and clamp.
    always_comb begin
        prod_sh = prod2 >>> FRAC_WIDTH;
        r_sum   = $signed({prod_sh[PROD_W-1], prod_sh})
                + $signed({{(R_W-COEF_WIDTH){icpt2[COEF_WIDTH-1]}}, icpt2});
        y_n     = r_sum[TOTAL_WIDTH-1:0];
        sat_n   = 1'b0;
        if (r_sum > Y_MAX_R) begin
            y_n   = Y_MAX;
            sat_n = 1'b1;
        end else if (r_sum < Y_MIN_R) begin
            y_n   = Y_MIN;
            sat_n = 1'b1;
        end
    end

    // Writes land at the edge; a sample captured on that same edge still reads the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                tbl_slope[i] <= slope_rst(i);
                tbl_icpt[i]  <= icpt_rst(i);
            end
        end else if (cfg_we && (int'(cfg_addr) < NUM_SEG)) begin
            tbl_slope[cfg_addr] <= cfg_slope;
            tbl_icpt[cfg_addr]  <= cfg_icpt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            x1        <= '0;
            slope1    <= '0;
            icpt1     <= '0;
            v2        <= 1'b0;
            prod2     <= '0;
            icpt2     <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (load1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    x1     <= in_x;
                    slope1 <= tbl_slope[k_sel];
                    icpt1  <= tbl_icpt[k_sel];
                end
            end
            if (load2) begin
                v2 <= v1;
                if (v1) begin
                    prod2 <= $signed({{COEF_WIDTH{x1[TOTAL_WIDTH-1]}}, x1})
                           * $signed({{TOTAL_WIDTH{slope1[COEF_WIDTH-1]}}, slope1});
                    icpt2 <= icpt1;
                end
            end
            if (load3) begin
                out_valid <= v2;
                if (v2) begin
                    out_y   <= y_n;
                    out_sat <= sat_n;
                end
            end
        end
    end

endmodule
